// File: rtl/home_inventory_pkg.sv
// Shared definitions for the home inventory calibration path.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package home_inventory_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int FRAC_BITS_DEF = 16;

  typedef logic [1:0] cal_state_t;

  localparam cal_state_t ST_IDLE = 2'd0;
  localparam cal_state_t ST_SUB  = 2'd1;
  localparam cal_state_t ST_MUL  = 2'd2;
  localparam cal_state_t ST_WR   = 2'd3;

  localparam logic [DATA_W_DEF-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W_DEF-1:0] SAT_MIN = 32'h8000_0000;

endpackage

// File: rtl/home_inventory_calib_if.sv
// Snapshot request / calibrated result bundle between register block and calibration engine.
// Latency: none (wiring only).
// Backpressure: none; start is a pulse, firmware holds inputs stable while busy.
interface home_inventory_calib_if #(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 32
);
  logic                       start;
  logic [3:0]                 num_ch;
  logic [NUM_CH*DATA_W-1:0]   raw_flat;
  logic [NUM_CH*DATA_W-1:0]   tare_flat;
  logic [NUM_CH*DATA_W-1:0]   scale_flat;
  logic [NUM_CH*DATA_W-1:0]   weight_flat;
  logic [NUM_CH-1:0]          weight_valid;
  logic [NUM_CH-1:0]          overflow;
  logic                       busy;
  logic                       done;
  logic                       missed_start;
  logic [15:0]                frame_cnt;

  // Register block side
  modport master (
    output start, num_ch, raw_flat, tare_flat, scale_flat,
    input  weight_flat, weight_valid, overflow, busy, done, missed_start, frame_cnt
  );

  // Calibration engine side
  modport slave (
    input  start, num_ch, raw_flat, tare_flat, scale_flat,
    output weight_flat, weight_valid, overflow, busy, done, missed_start, frame_cnt
  );
endinterface

// File: rtl/home_inventory_sat_shift.sv
// Q-format rescale: arithmetic right shift of a wide product, saturated to DATA_W signed.
// Latency: combinational.
// Backpressure: none.
module home_inventory_sat_shift
  import home_inventory_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic signed [2*DATA_W:0] prod,
  output logic [DATA_W-1:0]        result,
  output logic                     ovf
);
  localparam int PW = 2*DATA_W + 1;

  logic signed [PW-1:0]  q;
  logic [PW-DATA_W:0]    hi;

  // Shift floors toward -inf; the result fits only if every bit above the
  // DATA_W sign bit is a copy of it.
  always_comb begin
    q      = prod >>> FRAC_BITS;
    hi     = q[PW-1:DATA_W-1];
    ovf    = !((&hi) || !(|hi));
    result = q[DATA_W-1:0];
    if (ovf) begin
      result = q[PW-1] ? SAT_MIN : SAT_MAX;
    end
  end
endmodule

// File: rtl/home_inventory_calib.sv
// Per-channel calibration weight = ((raw - tare) * scale) >>> FRAC_BITS, one shared multiplier.
// Latency: 3 cycles per channel; last weight, done and busy=0 appear together after edge k+3n.
// Backpressure: none; start while busy is dropped and flagged in missed_start.
module home_inventory_calib
  import home_inventory_pkg::*;
#(
  parameter int NUM_CH    = 8,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  home_inventory_calib_if.slave bus
);
  localparam int PW = 2*DATA_W + 1;

  cal_state_t               state;
  logic [3:0]               ch;
  logic [3:0]               n_lat;
  logic [3:0]               n_sel;
  logic signed [DATA_W:0]   diff;
  logic signed [PW-1:0]     prod;

  logic [DATA_W-1:0]        raw_c;
  logic [DATA_W-1:0]        tare_c;
  logic [DATA_W-1:0]        scale_c;
  logic signed [DATA_W:0]   raw_x;
  logic signed [DATA_W:0]   tare_x;
  logic signed [PW-1:0]     diff_x;
  logic signed [PW-1:0]     scale_x;
  logic [DATA_W-1:0]        sat_res;
  logic                     sat_ovf;

  logic [NUM_CH*DATA_W-1:0] weight_q;
  logic [NUM_CH-1:0]        valid_q;
  logic [NUM_CH-1:0]        ovf_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     missed_q;
  logic [15:0]              frame_q;

  // Live channel operands, sign-extended so neither the subtract nor the multiply can wrap
  always_comb begin
    raw_c   = bus.raw_flat[ch*DATA_W +: DATA_W];
    tare_c  = bus.tare_flat[ch*DATA_W +: DATA_W];
    scale_c = bus.scale_flat[ch*DATA_W +: DATA_W];
    raw_x   = {raw_c[DATA_W-1], raw_c};
    tare_x  = {tare_c[DATA_W-1], tare_c};
    diff_x  = {{DATA_W{diff[DATA_W]}}, diff};
    scale_x = {{(DATA_W+1){scale_c[DATA_W-1]}}, scale_c};
    n_sel   = (bus.num_ch > 4'(NUM_CH)) ? 4'(NUM_CH) : bus.num_ch;
  end

  home_inventory_sat_shift #(
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_sat_shift (
    .prod  (prod),
    .result(sat_res),
    .ovf   (sat_ovf)
  );

  // Frame sequencer: SUB -> MUL -> WR per channel, results and status held for readback
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      ch       <= '0;
      n_lat    <= '0;
      diff     <= '0;
      prod     <= '0;
      weight_q <= '0;
      valid_q  <= '0;
      ovf_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      missed_q <= 1'b0;
      frame_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (bus.start && state != ST_IDLE) begin
        missed_q <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            n_lat    <= n_sel;
            ch       <= '0;
            valid_q  <= '0;
            ovf_q    <= '0;
            missed_q <= 1'b0;
            if (n_sel == 4'd0) begin
              done_q  <= 1'b1;
              frame_q <= frame_q + 16'd1;
            end else begin
              busy_q <= 1'b1;
              state  <= ST_SUB;
            end
          end
        end
        ST_SUB: begin
          diff  <= raw_x - tare_x;
          state <= ST_MUL;
        end
        ST_MUL: begin
          prod  <= diff_x * scale_x;
          state <= ST_WR;
        end
        default: begin
          weight_q[ch*DATA_W +: DATA_W] <= sat_res;
          valid_q[ch] <= 1'b1;
          if (sat_ovf) begin
            ovf_q[ch] <= 1'b1;
          end
          if (ch == n_lat - 4'd1) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            frame_q <= frame_q + 16'd1;
            state   <= ST_IDLE;
          end else begin
            ch    <= ch + 4'd1;
            state <= ST_SUB;
          end
        end
      endcase
    end
  end

  assign bus.weight_flat  = weight_q;
  assign bus.weight_valid = valid_q;
  assign bus.overflow     = ovf_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.missed_start = missed_q;
  assign bus.frame_cnt    = frame_q;

endmodule

// File: tb/tb_home_inventory_calib.sv
// Directed bench for the calibration engine: latency, rounding, saturation, missed starts, reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_home_inventory_calib;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   exp_frames;

  home_inventory_calib_if #(.NUM_CH(8), .DATA_W(32)) bus ();

  home_inventory_calib #(.NUM_CH(8), .DATA_W(32), .FRAC_BITS(16)) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Eight-channel golden table, products worked out by hand
  logic [31:0] t_raw   [8] = '{32'd100, 32'd300, 32'hFFFF_FFCE, 32'd1000,
                               32'd10, 32'hFFFF_FFFD, 32'd0, 32'd65536};
  logic [31:0] t_tare  [8] = '{32'd0, 32'd100, 32'd50, 32'd0, 32'd3, 32'd0, 32'd0, 32'd0};
  logic [31:0] t_scale [8] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0000_4000,
                               32'h0001_8000, 32'h0001_8000, 32'h7FFF_FFFF, 32'hFFFF_0000};
  logic [31:0] t_exp   [8] = '{32'd100, 32'd400, 32'hFFFF_FED4, 32'd250,
                               32'd10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_0000};

  function automatic logic [31:0] wgt(input int c);
    return bus.weight_flat[c*32 +: 32];
  endfunction

  task automatic set_ch(input int c, input logic [31:0] r, input logic [31:0] t, input logic [31:0] s);
    bus.raw_flat[c*32 +: 32]   = r;
    bus.tare_flat[c*32 +: 32]  = t;
    bus.scale_flat[c*32 +: 32] = s;
  endtask

  // Pulse start before edge k, follow the frame for `budget` edges; optional extra start before edge k+extra_at
  task automatic kick(input logic [3:0] n, input int extra_at, input int budget,
                      output int lat, output int done_cnt, output bit busy_seen);
    @(negedge clk);
    bus.num_ch = n;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat       = -1;
    done_cnt  = 0;
    busy_seen = 1'b0;
    for (int e = 0; e <= budget; e++) begin
      if (bus.done) begin
        if (lat < 0) lat = e;
        done_cnt++;
      end
      if (bus.busy) busy_seen = 1'b1;
      if (e == budget) break;
      @(negedge clk);
      bus.start = (e + 1 == extra_at);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.num_ch = 4'd0;
    bus.raw_flat = '0;
    bus.tare_flat = '0;
    bus.scale_flat = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b done=%b expected 0/0", bus.busy, bus.done);
    end
    checks++;
    if (bus.weight_flat !== '0 || bus.weight_valid !== 8'h00 || bus.overflow !== 8'h00) begin
      failures++;
      $display("FAIL reset_data weight=%h valid=%h ovf=%h expected all 0",
               bus.weight_flat, bus.weight_valid, bus.overflow);
    end
    checks++;
    if (bus.frame_cnt !== 16'd0 || bus.missed_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_cnt frame_cnt=%0d missed=%b expected 0/0", bus.frame_cnt, bus.missed_start);
    end
  endtask

  task automatic test_single();
    int lat, dc;
    bit bs;
    set_ch(0, 32'd1000, 32'd200, 32'h0001_0000);
    kick(4'd1, -1, 6, lat, dc, bs);
    exp_frames++;
    checks++;
    if (lat !== 3 || dc !== 1) begin
      failures++;
      $display("FAIL single_latency lat=%0d done_cycles=%0d expected 3/1", lat, dc);
    end
    checks++;
    if (wgt(0) !== 32'd800 || bus.weight_valid !== 8'h01) begin
      failures++;
      $display("FAIL single_weight w0=%h valid=%h expected 00000320/01", wgt(0), bus.weight_valid);
    end
    checks++;
    if (bus.frame_cnt !== 16'(exp_frames) || bus.busy !== 1'b0 || !bs) begin
      failures++;
      $display("FAIL single_status frame_cnt=%0d busy=%b busy_seen=%b expected %0d/0/1",
               bus.frame_cnt, bus.busy, bs, exp_frames);
    end
  endtask

  task automatic test_floor();
    int lat, dc;
    bit bs;
    set_ch(0, 32'hFFFF_FFF9, 32'd0, 32'h0000_8000);
    kick(4'd1, -1, 5, lat, dc, bs);
    exp_frames++;
    checks++;
    if (wgt(0) !== 32'hFFFF_FFFC || bus.overflow !== 8'h00) begin
      failures++;
      $display("FAIL floor_neg w0=%h ovf=%h expected fffffffc/00", wgt(0), bus.overflow);
    end
  endtask

  task automatic test_saturate();
    int lat, dc;
    bit bs;
    set_ch(0, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0002_0000);
    kick(4'd1, -1, 5, lat, dc, bs);
    exp_frames++;
    checks++;
    if (wgt(0) !== 32'h7FFF_FFFF || bus.overflow !== 8'h01) begin
      failures++;
      $display("FAIL sat_pos w0=%h ovf=%h expected 7fffffff/01", wgt(0), bus.overflow);
    end
    set_ch(0, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0002_0000);
    kick(4'd1, -1, 5, lat, dc, bs);
    exp_frames++;
    checks++;
    if (wgt(0) !== 32'h8000_0000 || bus.overflow !== 8'h01) begin
      failures++;
      $display("FAIL sat_neg w0=%h ovf=%h expected 80000000/01", wgt(0), bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    int lat, dc;
    bit bs;
    for (int c = 0; c < 8; c++) set_ch(c, t_raw[c], t_tare[c], t_scale[c]);
    kick(4'd8, 5, 27, lat, dc, bs);
    exp_frames++;
    checks++;
    if (lat !== 24 || dc !== 1) begin
      failures++;
      $display("FAIL b2b_latency lat=%0d done_cycles=%0d expected 24/1", lat, dc);
    end
    checks++;
    if (bus.missed_start !== 1'b1 || bus.frame_cnt !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL b2b_missed missed=%b frame_cnt=%0d expected 1/%0d",
               bus.missed_start, bus.frame_cnt, exp_frames);
    end
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (wgt(c) !== t_exp[c]) begin
        failures++;
        $display("FAIL b2b_weight ch=%0d got=%h expected %h", c, wgt(c), t_exp[c]);
      end
    end
    checks++;
    if (bus.weight_valid !== 8'hFF || bus.overflow !== 8'h00) begin
      failures++;
      $display("FAIL b2b_masks valid=%h ovf=%h expected ff/00", bus.weight_valid, bus.overflow);
    end
  endtask

  task automatic test_partial_keep();
    int lat, dc;
    bit bs;
    set_ch(0, 32'd1000, 32'd200, 32'h0001_0000);
    kick(4'd1, -1, 5, lat, dc, bs);
    exp_frames++;
    checks++;
    if (bus.missed_start !== 1'b0 || bus.weight_valid !== 8'h01) begin
      failures++;
      $display("FAIL keep_masks missed=%b valid=%h expected 0/01", bus.missed_start, bus.weight_valid);
    end
    checks++;
    if (wgt(0) !== 32'd800 || wgt(7) !== 32'hFFFF_0000 || wgt(3) !== 32'd250) begin
      failures++;
      $display("FAIL keep_weights w0=%h w3=%h w7=%h expected 00000320/000000fa/ffff0000",
               wgt(0), wgt(3), wgt(7));
    end
  endtask

  task automatic test_start_on_last_wr();
    int lat, dc;
    bit bs;
    kick(4'd1, 3, 7, lat, dc, bs);
    exp_frames++;
    checks++;
    if (lat !== 3 || dc !== 1 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL last_wr_start lat=%0d done_cycles=%0d busy=%b expected 3/1/0", lat, dc, bus.busy);
    end
    checks++;
    if (bus.missed_start !== 1'b1 || bus.frame_cnt !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL last_wr_missed missed=%b frame_cnt=%0d expected 1/%0d",
               bus.missed_start, bus.frame_cnt, exp_frames);
    end
  endtask

  task automatic test_zero_and_clamp();
    int lat, dc;
    bit bs;
    kick(4'd0, -1, 4, lat, dc, bs);
    exp_frames++;
    checks++;
    if (lat !== 0 || dc !== 1 || bs !== 1'b0) begin
      failures++;
      $display("FAIL zero_ch lat=%0d done_cycles=%0d busy_seen=%b expected 0/1/0", lat, dc, bs);
    end
    checks++;
    if (bus.frame_cnt !== 16'(exp_frames) || bus.weight_valid !== 8'h00 || bus.missed_start !== 1'b0) begin
      failures++;
      $display("FAIL zero_status frame_cnt=%0d valid=%h missed=%b expected %0d/00/0",
               bus.frame_cnt, bus.weight_valid, bus.missed_start, exp_frames);
    end
    set_ch(0, t_raw[0], t_tare[0], t_scale[0]);
    kick(4'd12, -1, 27, lat, dc, bs);
    exp_frames++;
    checks++;
    if (lat !== 24 || dc !== 1 || bus.weight_valid !== 8'hFF) begin
      failures++;
      $display("FAIL clamp_ch lat=%0d done_cycles=%0d valid=%h expected 24/1/ff", lat, dc, bus.weight_valid);
    end
    checks++;
    if (wgt(0) !== t_exp[0] || wgt(7) !== t_exp[7] || bus.frame_cnt !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL clamp_data w0=%h w7=%h frame_cnt=%0d expected %h/%h/%0d",
               wgt(0), wgt(7), bus.frame_cnt, t_exp[0], t_exp[7], exp_frames);
    end
  endtask

  task automatic test_reset_mid_frame();
    int dones;
    dones = 0;
    @(negedge clk);
    bus.num_ch = 4'd8;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // After edge k+9 channel 3 is in SUB; hit reset part-way through that cycle
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    exp_frames = 0;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.weight_flat !== '0 ||
        bus.weight_valid !== 8'h00 || bus.frame_cnt !== 16'd0 || bus.overflow !== 8'h00) begin
      failures++;
      $display("FAIL midframe_reset busy=%b done=%b valid=%h ovf=%h frame_cnt=%0d expected all 0",
               bus.busy, bus.done, bus.weight_valid, bus.overflow, bus.frame_cnt);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dones++;
    end
    checks++;
    if (dones !== 0 || bus.frame_cnt !== 16'(exp_frames)) begin
      failures++;
      $display("FAIL midframe_after activity=%0d frame_cnt=%0d expected 0/0", dones, bus.frame_cnt);
    end
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_frames = 0;
    rst        = 1'b1;
    test_reset();
    test_single();
    test_floor();
    test_saturate();
    test_back_to_back();
    test_partial_keep();
    test_start_on_last_wr();
    test_zero_and_clamp();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
